// File: rtl/incr_stream_fifo.sv
// incr_stream_fifo
// Streaming stage that adds a constant to each accepted word and buffers the
// results in a small FIFO. Input and output both use valid/ready handshakes.
// in_ready depends only on registered state and reset, never on out_ready,
// so a full FIFO cannot accept a word even when a pop happens in the same
// cycle. The head entry is read combinationally, which means a word pushed
// into an empty FIFO is presented in the very next cycle.
module incr_stream_fifo #(
    parameter int          DW    = 32,
    parameter int          DEPTH = 4,   // power of 2, at least 2
    parameter int unsigned INC   = 1
) (
    input  logic                     v_clk,
    input  logic                     v_rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [31:0]              accepted
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [DW-1:0] INC_C   = DW'(INC);

    // Storage for the incremented words. It has no reset because only
    // entries between rd_ptr and wr_ptr are ever observed.
    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [31:0]   accepted_reg;

    logic push;
    logic pop;

    // Status flags come straight from the occupancy register.
    assign full  = (count_reg == DEPTH_C);
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign accepted = accepted_reg;

    // Reset gates in_ready directly so nothing is taken while v_rst is high.
    assign in_ready  = !full && !v_rst;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr_reg];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Write the incremented word at the tail; the carry out is dropped.
    always_ff @(posedge v_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data + INC_C;
        end
    end

    // Pointer, occupancy and acceptance bookkeeping.
    always_ff @(posedge v_clk or posedge v_rst) begin
        if (v_rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            accepted_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg   <= wr_ptr_reg + AW'(1);
                accepted_reg <= accepted_reg + 32'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Simulation-only guards against overflow, underflow and bad occupancy.
    always @(posedge v_clk) begin
        if (!v_rst) begin
            assert (!(in_valid && in_ready && full))
                else $error("incr_stream_fifo: push while full");
            assert (!(out_valid && out_ready && empty))
                else $error("incr_stream_fifo: pop while empty");
            assert (count_reg <= DEPTH_C)
                else $error("incr_stream_fifo: count %0d exceeds depth", count_reg);
        end
    end
`endif

endmodule

// File: tb/tb_incr_stream_fifo.sv
// Directed and randomized bench for incr_stream_fifo. A queue-based model
// holds the words the stage should contain; every cycle the DUT outputs are
// compared against it, and popped DUT words are checked against directed lists.
module tb_incr_stream_fifo;

    localparam int DEPTH = 4;

    logic        v_clk = 1'b0;
    logic        v_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic [31:0] accepted;

    incr_stream_fifo #(.DW(32), .DEPTH(DEPTH), .INC(1)) dut (
        .v_clk    (v_clk),
        .v_rst    (v_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .accepted (accepted)
    );

    always #5 v_clk = ~v_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: words held (already incremented), total accepted.
    logic [31:0] q[$];
    logic [31:0] acc = '0;
    logic [31:0] dut_log[$];
    logic [31:0] exp_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, then advance the model at the edge.
    task automatic step(output bit pushed);
        bit m_push;
        bit m_pop;
        @(negedge v_clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("out_data", out_data, (q.size() > 0) ? q[0] : 32'h0);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("in_ready", in_ready, (q.size() < DEPTH) && !v_rst);
        chk("accepted", accepted, acc);
        m_push = in_valid && !v_rst && (q.size() < DEPTH);
        m_pop  = out_ready && (q.size() > 0);
        if (m_pop) dut_log.push_back(out_data);
        @(posedge v_clk);
        if (m_pop) void'(q.pop_front());
        if (m_push) begin
            q.push_back(in_data + 32'd1);
            acc = acc + 32'd1;
        end
        pushed = m_push;
        #1;
    endtask

    task automatic drain();
        bit p;
        int guard = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() > 0 && guard < 50) begin
            step(p);
            guard++;
        end
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, dut_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++) begin
            chk(tag, dut_log[i], exp_log[i]);
        end
        dut_log.delete();
        exp_log.delete();
    endtask

    initial begin
        bit p;
        int guard;
        int next;

        // Reset state while v_rst is held.
        @(posedge v_clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", count, 3'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_accepted", accepted, 32'h0);
        v_rst = 1'b0;

        // Single word.
        in_valid = 1'b1; in_data = 32'h5; out_ready = 1'b1;
        step(p);
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_data", out_data, 32'h6);
        step(p);
        chk("t1_empty", empty, 1'b1);
        chk("t1_accepted", accepted, 32'd1);
        step(p);
        exp_log.push_back(32'h6);
        check_log("t1_log");

        // Fill to full, then a held fifth word.
        out_ready = 1'b0;
        for (int v = 10; v <= 13; v++) begin
            in_valid = 1'b1; in_data = 32'(v);
            step(p);
        end
        chk("fill_full", full, 1'b1);
        chk("fill_in_ready", in_ready, 1'b0);
        chk("fill_count", count, 3'd4);
        in_valid = 1'b1; in_data = 32'd14;
        step(p);
        chk("fill_held_accept", p, 1'b0);
        out_ready = 1'b1;
        guard = 0;
        do begin
            step(p);
            guard++;
        end while (!p && guard < 20);
        chk("fill_14_taken", p, 1'b1);
        drain();
        for (int v = 11; v <= 15; v++) exp_log.push_back(32'(v));
        check_log("fill_log");

        // Wrap-around with random backpressure and a fresh accepted count.
        v_rst = 1'b1; #1; v_rst = 1'b0;
        q.delete(); acc = '0;
        next = 0; guard = 0;
        while (next < 9 && guard < 500) begin
            in_valid = 1'b1; in_data = 32'(next);
            out_ready = 1'($urandom_range(0, 1));
            step(p);
            if (p) next++;
            guard++;
        end
        chk("wrap_pushed", next, 9);
        drain();
        chk("wrap_accepted", accepted, 32'd9);
        chk("wrap_count", count, 3'd0);
        for (int v = 1; v <= 9; v++) exp_log.push_back(32'(v));
        check_log("wrap_log");

        // Carry is discarded.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF; step(p);
        in_valid = 1'b1; in_data = 32'h7FFF_FFFF; step(p);
        drain();
        exp_log.push_back(32'h0000_0000);
        exp_log.push_back(32'h8000_0000);
        check_log("ovf_log");

        // Simultaneous push/pop at count 2.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'd200; step(p);
        in_valid = 1'b1; in_data = 32'd201; step(p);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 32'(100 + i);
            step(p);
            chk("sim_count", count, 3'd2);
        end
        drain();
        exp_log.push_back(32'd201);
        exp_log.push_back(32'd202);
        for (int v = 101; v <= 120; v++) exp_log.push_back(32'(v));
        check_log("sim_log");

        // Asynchronous reset between edges with three words held.
        out_ready = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            in_valid = 1'b1; in_data = 32'(v);
            step(p);
        end
        in_valid = 1'b0;
        chk("pre_rst_count", count, 3'd3);
        #2;
        v_rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_count", count, 3'd0);
        chk("arst_accepted", accepted, 32'd0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_out_data", out_data, 32'h0);
        q.delete(); acc = '0;
        in_valid = 1'b1; in_data = 32'd50;
        step(p);
        in_valid = 1'b0;
        v_rst = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'd7;
        step(p);
        chk("post_rst_push", p, 1'b1);
        drain();
        chk("post_rst_accepted", accepted, 32'd1);
        exp_log.push_back(32'd8);
        check_log("post_rst_log");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/incr_stream_fifo.md
Name: incr_stream_fifo

Overview:
- Datapath stage between the DPI-C driver and the DPI-C monitor in the simulation top.
- Accepts 32-bit words from the driver over a valid/ready handshake and adds a constant increment to each word.
- Buffers the results in a small FIFO and presents them to the monitor over a valid/ready handshake.
- Replaces the bare combinational increment, so that backpressure from the monitor side can be exercised.

Parameters:
- DW, 32: data width in bits.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.
- INC, 1: constant added to each accepted word.

Ports:
- v_clk  in  1  sole clock. All state updates on posedge.
- v_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream word present.
- in_ready  out  1  stage can accept a word this cycle.
- in_data  in  DW  upstream word.
- out_valid  out  1  head entry available.
- out_ready  in  1  downstream takes the head entry this cycle.
- out_data  out  DW  head entry, already incremented.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- accepted  out  32  total words pushed since reset. Wraps at 2^32.

Behaviour:
- Push condition: push = in_valid && in_ready.
  - in_ready = !full && !v_rst.
  - in_ready is combinational from registered state only; it never depends on out_ready, so there is no full-state pass-through.
- Pop condition: pop = out_valid && out_ready.
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when !empty, else 0.
- Arithmetic: stored value = (in_data + INC) mod 2^DW. Carry out is discarded, e.g. 32'hFFFF_FFFF with INC=1 stores 32'h0.
- Latency:
  - A word pushed at edge N is visible on out_data with out_valid=1 in the cycle after edge N when the FIFO was empty.
  - There is no same-cycle bypass.
- Ordering: strict FIFO. Words are neither dropped nor duplicated.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0.
  - count is tracked in a separate register.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - Legal at any occupancy from 1 to DEPTH-1.
  - At DEPTH only pop is possible, because in_ready=0.
  - At 0 only push is possible, because out_valid=0.
- Stall rule: while out_valid=1 and out_ready=0, out_data must hold stable.
- accepted counter: increments by 1 on every push.
- Reset while v_rst=1 (asynchronous; takes effect immediately, mid-transfer included):
  - wr_ptr=0, rd_ptr=0, count=0, accepted=0.
  - empty=1, full=0, out_valid=0, out_data=0, in_ready=0.
  - Memory contents are not reset and are don't-care.
  - A word presented during reset is not accepted.
  - First acceptance is possible on the first posedge after v_rst deasserts.
- Protocol assumption: once in_valid is raised, in_data holds until accepted.
- Assertions required in RTL under simulation:
  - No push when full.
  - No pop when empty.
  - count never exceeds DEPTH.

Test Plan:
- Reset then single word: v_rst pulse, then in_data=32'h0000_0005 pushed with out_ready=1.
  - Next cycle: out_valid=1, out_data=32'h0000_0006.
  - Following cycle: empty=1, accepted=1.
- Fill to full: out_ready=0, push 10,11,12,13.
  - Then full=1, in_ready=0, count=4.
  - A fifth in_valid word (14) is held, not lost.
  - Raise out_ready: outputs 11,12,13,14,15 in order.
- Wrap-around: run 9 push/pop pairs at DEPTH=4 with data 0..8 under random out_ready.
  - Outputs are 1..9 in order.
  - accepted=9, final count=0.
- Overflow arithmetic: push 32'hFFFF_FFFF and 32'h7FFF_FFFF.
  - Outputs are 32'h0000_0000 and 32'h8000_0000.
- Simultaneous push/pop at count=2 over 20 cycles (in_valid=1, out_ready=1, data 100..119):
  - count stays 2.
  - Outputs follow the two pre-loaded words, then 101..118.
- Reset mid-operation: assert v_rst asynchronously, between edges, with count=3.
  - Immediately: out_valid=0, count=0, accepted=0, in_ready=0.
  - After release, push 7: output is 8, with none of the pre-reset words.
